// File: rtl/pe_row_ctrl.sv
// pe_row_ctrl: job sequencer for one 3-tap PE (clear, load 3 weights, stream a row, one psum per window).
// Optional PE_ROW_CTRL_STRIDE2_EN: emit psums only for windows starting at even indices.
module pe_row_ctrl #(
  parameter int IFMAP_W  = 8,
  parameter int WEIGHT_W = 8,
  parameter int PSUM_W   = 20,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    cfg_len,
  output logic                busy,
  output logic                done,
  input  logic [WEIGHT_W-1:0] w_data,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [IFMAP_W-1:0]  x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic [IFMAP_W-1:0]  pe_ifmap,
  output logic                pe_ifmap_wen,
  output logic [WEIGHT_W-1:0] pe_weight,
  output logic                pe_weight_wen,
  output logic                pe_reg_clear,
  input  logic [PSUM_W-1:0]   pe_psum,
  output logic [PSUM_W-1:0]   out_psum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_len
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, x_cnt_q, x_cnt_d, x_cnt_inc;
  logic [1:0] w_cnt_q, w_cnt_d;
  logic out_valid_q, out_valid_d, err_len_q, err_len_d;
  logic w_hs, x_hs, emit;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign pe_reg_clear  = state_q == CLEAR;
  assign w_ready       = state_q == LOAD_W;
  // a stalled psum freezes the PE window, so no new ifmap may shift in
  assign x_ready       = state_q == STREAM && x_cnt_q != len_q && !(out_valid_q && !out_ready);
  assign w_hs          = w_valid && w_ready;
  assign x_hs          = x_valid && x_ready;
  assign x_cnt_inc     = x_cnt_q + 1'b1;
  assign pe_ifmap      = x_data;
  assign pe_ifmap_wen  = x_hs;
  assign pe_weight     = w_data;
  assign pe_weight_wen = w_hs;
  assign out_psum      = pe_psum;
  assign out_valid     = out_valid_q;
  assign err_len       = err_len_q;
`ifdef PE_ROW_CTRL_STRIDE2_EN
  assign emit = x_hs && x_cnt_inc >= LEN_W'(3) && x_cnt_inc[0];
`else
  assign emit = x_hs && x_cnt_inc >= LEN_W'(3);
`endif
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    x_cnt_d     = x_hs ? x_cnt_inc : x_cnt_q;
    w_cnt_d     = w_hs ? w_cnt_q + 2'd1 : w_cnt_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    err_len_d   = err_len_q;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_len >= LEN_W'(3)) begin
          state_d   = CLEAR;
          len_d     = cfg_len;
          err_len_d = 1'b0;
        end else begin
          err_len_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = LOAD_W;
        x_cnt_d = '0;
        w_cnt_d = '0;
      end
      LOAD_W: state_d = (w_hs && w_cnt_q == 2'd2) ? STREAM : LOAD_W;
      STREAM: state_d = (x_cnt_q == len_q && (!out_valid_q || out_ready)) ? DONE : STREAM;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      x_cnt_q     <= '0;
      w_cnt_q     <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      x_cnt_q     <= x_cnt_d;
      w_cnt_q     <= w_cnt_d;
      out_valid_q <= out_valid_d;
      err_len_q   <= err_len_d;
    end
  end
endmodule

// File: tb/tb_pe_row_ctrl.sv
// tb_pe_row_ctrl: directed bench for pe_row_ctrl with a behavioural 3-tap PE model.
module tb_pe_row_ctrl;
  localparam int IW = 8, WW = 8, PW = 20, LW = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [LW-1:0] cfg_len = '0;
  logic busy, done, w_ready, x_ready, pe_ifmap_wen, pe_weight_wen, pe_reg_clear, out_valid, err_len;
  logic [WW-1:0] w_data = '0, pe_weight;
  logic [IW-1:0] x_data = '0, pe_ifmap;
  logic w_valid = 0, x_valid = 0, out_ready = 1;
  logic [PW-1:0] pe_psum, out_psum;
  int tests = 0, fails = 0;

  pe_row_ctrl #(.IFMAP_W(IW), .WEIGHT_W(WW), .PSUM_W(PW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .pe_ifmap(pe_ifmap), .pe_ifmap_wen(pe_ifmap_wen), .pe_weight(pe_weight),
    .pe_weight_wen(pe_weight_wen), .pe_reg_clear(pe_reg_clear), .pe_psum(pe_psum),
    .out_psum(out_psum), .out_valid(out_valid), .out_ready(out_ready), .err_len(err_len));

  always #5 clk = ~clk;

  // PE model: tap 0 holds the oldest element
  logic signed [IW-1:0] xt [3] = '{default: 0};
  logic signed [WW-1:0] wt [3] = '{default: 0};
  always @(posedge clk) begin
    if (pe_reg_clear) begin
      xt <= '{default: 0};
      wt <= '{default: 0};
    end else begin
      if (pe_ifmap_wen) begin xt[0] <= xt[1]; xt[1] <= xt[2]; xt[2] <= pe_ifmap; end
      if (pe_weight_wen) begin wt[0] <= wt[1]; wt[1] <= wt[2]; wt[2] <= pe_weight; end
    end
  end
  always_comb pe_psum = PW'(int'(xt[0]) * int'(wt[0]) + int'(xt[1]) * int'(wt[1]) + int'(xt[2]) * int'(wt[2]));

  int cyc = 0, done_n = 0, done_cyc = 0, clr_n = 0, clr_cyc = 0, xh_n = 0, xh_cyc = 0, wh_n = 0, wh_cyc = 0;
  logic signed [PW-1:0] ps_q [$];
  int ps_cyc [$];
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid && out_ready) begin ps_q.push_back(out_psum); ps_cyc.push_back(cyc); end
      if (done) begin done_n++; done_cyc = cyc; end
      if (pe_reg_clear) begin clr_n++; clr_cyc = cyc; end
      if (pe_ifmap_wen) begin xh_n++; xh_cyc = cyc; end
      if (pe_weight_wen) begin wh_n++; wh_cyc = cyc; end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start = 1;
    cfg_len = LW'(len);
    tick();
    start = 0;
  endtask

  task automatic send_w(input int v, input bit stall);
    if (stall) repeat ($urandom_range(0, 2)) tick();
    w_data = WW'(v);
    w_valid = 1;
    for (int k = 0; k < 40 && !w_ready; k++) tick();
    chk("w_ready_wait", w_ready, 1);
    tick();
    w_valid = 0;
  endtask

  task automatic send_x(input int v, input bit stall);
    if (stall) repeat ($urandom_range(0, 2)) tick();
    x_data = IW'(v);
    x_valid = 1;
    for (int k = 0; k < 40 && !x_ready; k++) tick();
    chk("x_ready_wait", x_ready, 1);
    tick();
    x_valid = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) tick();
    chk("done_seen", done, 1);
    tick();
    chk("idle_after_done", busy, 0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
    chk({tag, "_x_ready"}, x_ready, 0);
    chk({tag, "_clear"}, pe_reg_clear, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d0, c0, x0, w0;
    tick(); tick();
    chk_idle_outs("reset");
    chk("reset_err_len", err_len, 0);
    rst = 0;
    tick();

    // bad length, then a minimal valid job clears the error
    c0 = clr_n; d0 = done_n; b = ps_q.size();
    start_job(2);
    chk("badlen_err", err_len, 1);
    chk_idle_outs("badlen");
    tick(); tick();
    chk("badlen_err_sticky", err_len, 1);
    chk("badlen_no_clear", clr_n - c0, 0);
    chk("badlen_no_done", done_n - d0, 0);
    start_job(3);
    chk("len3_err_clr", err_len, 0);
    chk("len3_busy", busy, 1);
    send_w(1, 0); send_w(1, 0); send_w(1, 0);
    send_x(2, 0); send_x(3, 0); send_x(4, 0);
    wait_done();
    chk("len3_npsum", ps_q.size() - b, 1);
    if (ps_q.size() > b) chk("len3_psum", ps_q[b], 9);

    // reset in the middle of a stream
    b = ps_q.size();
    start_job(8);
    send_w(1, 0); send_w(1, 0); send_w(1, 0);
    for (int i = 1; i <= 4; i++) send_x(i, 0);
    rst = 1;
    #1;
    chk_idle_outs("midrst");
    chk("midrst_err", err_len, 0);
    tick();
    rst = 0;
    tick();
    chk("midrst_idle", busy, 0);
    chk("midrst_npsum", ps_q.size() - b, 1);

`ifdef PE_ROW_CTRL_STRIDE2_EN
    b = ps_q.size();
    start_job(7);
    send_w(1, 0); send_w(1, 0); send_w(1, 0);
    for (int i = 1; i <= 7; i++) send_x(i, 0);
    wait_done();
    chk("s2_len7_npsum", ps_q.size() - b, 3);
    if (ps_q.size() - b == 3) begin
      chk("s2_len7_p0", ps_q[b], 6);
      chk("s2_len7_p1", ps_q[b+1], 12);
      chk("s2_len7_p2", ps_q[b+2], 18);
    end
    b = ps_q.size(); d0 = done_n; x0 = xh_n;
    start_job(6);
    send_w(1, 0); send_w(1, 0); send_w(1, 0);
    for (int i = 1; i <= 6; i++) send_x(i, 0);
    wait_done();
    chk("s2_len6_npsum", ps_q.size() - b, 2);
    if (ps_q.size() - b == 2) begin
      chk("s2_len6_p0", ps_q[b], 6);
      chk("s2_len6_p1", ps_q[b+1], 12);
    end
    chk("s2_len6_xhs", xh_n - x0, 6);
    chk("s2_len6_done_n", done_n - d0, 1);
    chk("s2_len6_done_cyc", done_cyc - xh_cyc, 2);
`else
    // basic job: back-to-back psums, clear right before the weights
    b = ps_q.size(); c0 = clr_n;
    start_job(5);
    send_w(1, 0); send_w(2, 0); send_w(3, 0);
    chk("basic_clear_n", clr_n - c0, 1);
    chk("basic_w_after_clr", wh_cyc - clr_cyc, 3);
    for (int i = 1; i <= 5; i++) send_x(i, 0);
    wait_done();
    chk("basic_npsum", ps_q.size() - b, 3);
    if (ps_q.size() - b == 3) begin
      chk("basic_p0", ps_q[b], 14);
      chk("basic_p1", ps_q[b+1], 20);
      chk("basic_p2", ps_q[b+2], 26);
      chk("basic_consec", ps_cyc[b+2] - ps_cyc[b], 2);
      chk("basic_done_cyc", done_cyc - ps_cyc[b+2], 1);
    end

    // backpressure on the first psum
    b = ps_q.size();
    out_ready = 0;
    start_job(4);
    send_w(-1, 0); send_w(0, 0); send_w(1, 0);
    send_x(10, 0); send_x(20, 0); send_x(30, 0);
    x_data = 8'd40;
    x_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_psum", $signed(out_psum), 20);
      chk("bp_x_blocked", x_ready, 0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_x_release", x_ready, 1);
    tick();
    x_valid = 0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_psum", $signed(out_psum), 20);
    wait_done();
    chk("bp_npsum", ps_q.size() - b, 2);

    // randomly stalled sources, surplus data held afterwards
    b = ps_q.size(); d0 = done_n; x0 = xh_n; w0 = wh_n;
    start_job(6);
    for (int i = 0; i < 3; i++) send_w(2, 1);
    for (int i = 0; i < 6; i++) send_x(1, 1);
    x_valid = 1;
    w_valid = 1;
    wait_done();
    repeat (4) tick();
    x_valid = 0;
    w_valid = 0;
    chk("stall_npsum", ps_q.size() - b, 4);
    for (int i = b; i < ps_q.size(); i++) chk("stall_psum", ps_q[i], 6);
    chk("stall_xhs", xh_n - x0, 6);
    chk("stall_whs", wh_n - w0, 3);
    chk("stall_done_n", done_n - d0, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
